serial_adder: RTL

- Bit-serial N-bit adder controller. Holds both operands in shift registers and feeds them LSB-first, one bit per clock, into a single `full_adder` instance.
- Captures each `sum` bit and registers `carry_out` as the next-cycle carry-in.
- Trades area for latency: WIDTH+1 cycles per add. Sits between the operand source and result consumer, with a start/busy/done handshake on both sides.

---
 rtl/serial_adder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Both operands are parked in shift registers and
//   fed LSB-first, one bit per clock, through a single full_adder. The carry
//   out of each bit is registered and becomes the carry in of the next bit.
//   One add takes WIDTH RUN cycles followed by one DONE cycle.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When defined, an extra input `sub` selects a - b (b inverted, carry-in
//     forced to 1). The result cout=1 then means "no borrow".
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request, accepted only while idle
//   a, b     in   WIDTH-bit operands, sampled on an accepted start
//   cin      in   initial carry, sampled on an accepted start
//   sub      in   (SERIAL_ADDER_SUB_EN only) subtract select, sampled on start
//   busy     out  high while running and during the done cycle
//   done     out  one-cycle pulse, sum/cout valid
//   sum      out  registered result, held until the next completion
//   cout     out  registered final carry, held until the next completion
// -----------------------------------------------------------------------------

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res_sr;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_fa_sum;
   logic             w_fa_cout;
   logic             w_last;
   logic [WIDTH:0]   w_res_wide;
   logic [WIDTH-1:0] w_res_next;
   logic             w_unused_lsb;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   full_adder u_fa (
      .i_a (r_a_sr[0]),
      .i_b (r_b_sr[0]),
      .i_c (r_carry),
      .o_s (w_fa_sum),
      .o_c (w_fa_cout)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result
   // has arrived at position 0. The bit shifted out is always the cleared
   // initial value and carries no information.
   assign w_res_wide   = {w_fa_sum, r_res_sr};
   assign w_res_next   = w_res_wide[WIDTH:1];
   assign w_unused_lsb = w_res_wide[0];

   assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: a + ~b + 1.
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub ? 1'b1 : cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DONE:  begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_res_sr <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sr   <= a;
                  r_b_sr   <= w_b_load;
                  r_carry  <= w_c_load;
                  r_cnt    <= '0;
                  r_res_sr <= '0;
               end
            end
            S_RUN: begin
               r_res_sr <= w_res_next;
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_carry  <= w_fa_cout;
               r_cnt    <= r_cnt + CW'(1);
               // Publish the result including the bit computed this cycle.
               if (w_last) begin
                  r_sum  <= w_res_next;
                  r_cout <= w_fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
